// File: rtl/dcache_flush_ctrl.sv
// Halt-time data cache flush engine: walks every set/way, writes back dirty blocks word by word,
// invalidates each visited block, optionally stores the hit counter, then raises a sticky flushed.
module dcache_flush_ctrl #(
   parameter int unsigned SETS      = 8,
   parameter int unsigned WAYS      = 2,
   parameter int unsigned WORDS     = 2,
   parameter int unsigned TAGW      = 26,
   parameter bit          EMIT_HITS = 1'b1,
   parameter logic [31:0] HITADDR   = 32'h3100,
   localparam int unsigned SW = (SETS  > 1) ? $clog2(SETS)  : 1,
   localparam int unsigned WW = (WAYS  > 1) ? $clog2(WAYS)  : 1,
   localparam int unsigned BW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            halt,
   input  logic [31:0]     hit_count,
   output logic [SW-1:0]   fl_set,
   output logic [WW-1:0]   fl_way,
   output logic [BW-1:0]   fl_word,
   input  logic            line_valid,
   input  logic            line_dirty,
   input  logic [TAGW-1:0] line_tag,
   input  logic [31:0]     line_word,
   output logic            fl_inval,
   output logic            dWEN,
   output logic [31:0]     daddr,
   output logic [31:0]     dstore,
   input  logic            dwait,
   output logic            busy,
   output logic            flushed
);

   localparam int unsigned SetBits  = $clog2(SETS);
   localparam int unsigned WordBits = $clog2(WORDS);

   localparam logic [SW-1:0] LastSet  = SW'(SETS - 1);
   localparam logic [WW-1:0] LastWay  = WW'(WAYS - 1);
   localparam logic [BW-1:0] LastWord = BW'(WORDS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StWb,
      StInval,
      StNext,
      StHitcnt,
      StDone
   } state_e;

   state_e        state_q, state_d;
   logic [SW-1:0] set_q, set_d;
   logic [WW-1:0] way_q, way_d;
   logic [BW-1:0] word_q, word_d;
   logic [31:0]   hits_q, hits_d;
   logic [31:0]   line_addr;

   // {tag, set, word, byte}; unused index fields are zero-width in the real address.
   always_comb begin
      line_addr = (32'(line_tag) << (SetBits + WordBits + 2))
                | (32'(set_q) << (WordBits + 2))
                | (32'(word_q) << 2);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= StIdle;
         set_q   <= '0;
         way_q   <= '0;
         word_q  <= '0;
         hits_q  <= '0;
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
         way_q   <= way_d;
         word_q  <= word_d;
         hits_q  <= hits_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      set_d    = set_q;
      way_d    = way_q;
      word_d   = word_q;
      hits_d   = hits_q;
      dWEN     = 1'b0;
      daddr    = '0;
      dstore   = '0;
      fl_inval = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (halt) begin
               state_d = StCheck;
               set_d   = '0;
               way_d   = '0;
               word_d  = '0;
               hits_d  = hit_count;
            end
         end
         StCheck: begin
            if (line_valid && line_dirty) begin
               word_d  = '0;
               state_d = StWb;
            end else if (line_valid) begin
               state_d = StInval;
            end else begin
               state_d = StNext;
            end
         end
         StWb: begin
            dWEN   = 1'b1;
            daddr  = line_addr;
            dstore = line_word;
            if (!dwait) begin
               if (word_q == LastWord) begin
                  word_d  = '0;
                  state_d = StInval;
               end else begin
                  word_d = word_q + BW'(1);
               end
            end
         end
         StInval: begin
            fl_inval = 1'b1;
            state_d  = StNext;
         end
         StNext: begin
            if (way_q == LastWay && set_q == LastSet) begin
               state_d = EMIT_HITS ? StHitcnt : StDone;
            end else begin
               if (way_q == LastWay) begin
                  way_d = '0;
                  set_d = set_q + SW'(1);
               end else begin
                  way_d = way_q + WW'(1);
               end
               state_d = StCheck;
            end
         end
         StHitcnt: begin
            dWEN   = 1'b1;
            daddr  = HITADDR;
            dstore = hits_q;
            if (!dwait) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign fl_set  = set_q;
   assign fl_way  = way_q;
   assign fl_word = word_q;
   assign busy    = (state_q != StIdle) && (state_q != StDone);
   assign flushed = (state_q == StDone);

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl: three instances (default, no hit write, 4x1x4 geometry)
// each backed by a small tag/data array model; memory writes are logged and checked in order.
module tb_dcache_flush_ctrl;

   logic        CLK;
   logic        nRST;
   logic [31:0] hit_count;
   logic        dwait;
   logic        stall_en;
   logic        model_clr;

   int n_tests;
   int n_fail;

   // ---------------- instance A: defaults ----------------
   logic        halt_a;
   logic [2:0]  fl_set_a;
   logic [0:0]  fl_way_a, fl_word_a;
   logic        lv_a, ld_a, fl_inval_a, dWEN_a, busy_a, flushed_a;
   logic [25:0] lt_a;
   logic [31:0] lw_a, daddr_a, dstore_a;
   logic [15:0] va_a, da_a, kill_a;
   logic [25:0] tg_a [16];
   logic [31:0] wd_a [16][2];
   logic [3:0]  idx_a;

   // ---------------- instance B: EMIT_HITS=0 ----------------
   logic        halt_b;
   logic [2:0]  fl_set_b;
   logic [0:0]  fl_way_b, fl_word_b;
   logic        lv_b, fl_inval_b, dWEN_b, busy_b, flushed_b;
   logic [31:0] daddr_b, dstore_b;
   logic [15:0] va_b, kill_b;
   logic [3:0]  idx_b;

   // ---------------- instance C: 4 sets, 1 way, 4 words ----------------
   logic        halt_c;
   logic [1:0]  fl_set_c, fl_word_c;
   logic [0:0]  fl_way_c;
   logic        lv_c, ld_c, fl_inval_c, dWEN_c, busy_c, flushed_c;
   logic [25:0] lt_c;
   logic [31:0] lw_c, daddr_c, dstore_c;
   logic [3:0]  va_c, da_c, kill_c;
   logic [25:0] tg_c [4];
   logic [31:0] wd_c [4][4];

   assign idx_a = {fl_set_a, fl_way_a};
   assign lv_a  = va_a[idx_a] & ~kill_a[idx_a];
   assign ld_a  = da_a[idx_a] & ~kill_a[idx_a];
   assign lt_a  = tg_a[idx_a];
   assign lw_a  = wd_a[idx_a][fl_word_a];

   assign idx_b = {fl_set_b, fl_way_b};
   assign lv_b  = va_b[idx_b] & ~kill_b[idx_b];

   assign lv_c = va_c[fl_set_c] & ~kill_c[fl_set_c];
   assign ld_c = da_c[fl_set_c] & ~kill_c[fl_set_c];
   assign lt_c = tg_c[fl_set_c];
   assign lw_c = wd_c[fl_set_c][fl_word_c];

   dcache_flush_ctrl u_dut_a (
      .CLK(CLK), .nRST(nRST), .halt(halt_a), .hit_count(hit_count),
      .fl_set(fl_set_a), .fl_way(fl_way_a), .fl_word(fl_word_a),
      .line_valid(lv_a), .line_dirty(ld_a), .line_tag(lt_a), .line_word(lw_a),
      .fl_inval(fl_inval_a), .dWEN(dWEN_a), .daddr(daddr_a), .dstore(dstore_a),
      .dwait(dwait), .busy(busy_a), .flushed(flushed_a)
   );

   dcache_flush_ctrl #(.EMIT_HITS(1'b0)) u_dut_b (
      .CLK(CLK), .nRST(nRST), .halt(halt_b), .hit_count(hit_count),
      .fl_set(fl_set_b), .fl_way(fl_way_b), .fl_word(fl_word_b),
      .line_valid(lv_b), .line_dirty(1'b0), .line_tag(26'd0), .line_word(32'd0),
      .fl_inval(fl_inval_b), .dWEN(dWEN_b), .daddr(daddr_b), .dstore(dstore_b),
      .dwait(dwait), .busy(busy_b), .flushed(flushed_b)
   );

   dcache_flush_ctrl #(.SETS(4), .WAYS(1), .WORDS(4), .TAGW(26)) u_dut_c (
      .CLK(CLK), .nRST(nRST), .halt(halt_c), .hit_count(hit_count),
      .fl_set(fl_set_c), .fl_way(fl_way_c), .fl_word(fl_word_c),
      .line_valid(lv_c), .line_dirty(ld_c), .line_tag(lt_c), .line_word(lw_c),
      .fl_inval(fl_inval_c), .dWEN(dWEN_c), .daddr(daddr_c), .dstore(dstore_c),
      .dwait(dwait), .busy(busy_c), .flushed(flushed_c)
   );

   // ---------------- memory side: stall generator and write log ----------------
   int          scnt;
   logic        any_wen;
   logic [31:0] any_addr, any_data;
   logic [31:0] log_addr [64];
   logic [31:0] log_data [64];
   int          nlog, ninval, overlap, unstable, way_nz, rises;
   logic [3:0]  last_inval, first_sw;
   logic        seen, prev_fl, prev_stall;
   logic [31:0] prev_addr, prev_data;

   assign dwait    = stall_en & dWEN_a & (scnt < 3);
   assign any_wen  = dWEN_a | dWEN_b | dWEN_c;
   assign any_addr = dWEN_a ? daddr_a : (dWEN_b ? daddr_b : daddr_c);
   assign any_data = dWEN_a ? dstore_a : (dWEN_b ? dstore_b : dstore_c);

   always @(posedge CLK) begin
      if (model_clr) begin
         kill_a <= '0; kill_b <= '0; kill_c <= '0;
         nlog <= 0; ninval <= 0; overlap <= 0; unstable <= 0; way_nz <= 0; rises <= 0;
         last_inval <= '0; first_sw <= '0; seen <= 1'b0; prev_fl <= 1'b0;
         prev_stall <= 1'b0; prev_addr <= '0; prev_data <= '0; scnt <= 0;
      end else begin
         if (fl_inval_a) begin
            kill_a[idx_a] <= 1'b1;
            last_inval    <= idx_a;
         end
         if (fl_inval_b) kill_b[idx_b] <= 1'b1;
         if (fl_inval_c) kill_c[fl_set_c] <= 1'b1;
         if (fl_inval_a || fl_inval_b || fl_inval_c) ninval <= ninval + 1;
         if (any_wen && !dwait && nlog < 64) begin
            log_addr[nlog] <= any_addr;
            log_data[nlog] <= any_data;
            nlog           <= nlog + 1;
         end
         if ((dWEN_a && fl_inval_a) || (dWEN_b && fl_inval_b) || (dWEN_c && fl_inval_c))
            overlap <= overlap + 1;
         if (dWEN_a && prev_stall && (daddr_a != prev_addr || dstore_a != prev_data))
            unstable <= unstable + 1;
         prev_stall <= dWEN_a && dwait;
         prev_addr  <= daddr_a;
         prev_data  <= dstore_a;
         scnt       <= (dWEN_a && dwait) ? scnt + 1 : 0;
         if (busy_c && fl_way_c != 1'b0) way_nz <= way_nz + 1;
         prev_fl <= flushed_a;
         if (flushed_a && !prev_fl) rises <= rises + 1;
         if (busy_a && !seen) begin
            seen     <= 1'b1;
            first_sw <= idx_a;
         end
      end
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic sel_flushed(input int which);
      case (which)
         0:       return flushed_a;
         1:       return flushed_b;
         default: return flushed_c;
      endcase
   endfunction

   task automatic reset_all();
      nRST = 1'b0; model_clr = 1'b1; stall_en = 1'b0;
      halt_a = 1'b0; halt_b = 1'b0; halt_c = 1'b0;
      repeat (2) @(posedge CLK);
      #2 nRST = 1'b1;
      @(posedge CLK);
      #1 model_clr = 1'b0;
   endtask

   // Counts clock edges after the halt-sampling edge until flushed is seen.
   task automatic wait_flushed(input int which, output int cycles);
      bit done;
      done   = 1'b0;
      cycles = 0;
      while (!done && cycles < 600) begin
         @(posedge CLK);
         #1 cycles++;
         done = sel_flushed(which);
      end
      if (!done) check("flush timeout", 32'd0, 32'd1);
   endtask

   task automatic run_flush(input int which, output int cycles);
      @(posedge CLK);
      #1;
      case (which)
         0:       halt_a = 1'b1;
         1:       halt_b = 1'b1;
         default: halt_c = 1'b1;
      endcase
      @(posedge CLK);
      #1 halt_a = 1'b0; halt_b = 1'b0; halt_c = 1'b0;
      hit_count = 32'hDEAD_BEEF;
      wait_flushed(which, cycles);
   endtask

   task automatic load_a_scenario2();
      va_a = '0; da_a = '0;
      va_a[11] = 1'b1; da_a[11] = 1'b1;
      tg_a[11] = 26'h0ABCDEF;
      wd_a[11][0] = 32'h1111_1111;
      wd_a[11][1] = 32'h2222_2222;
   endtask

   initial begin
      int cyc;
      int k;
      n_tests = 0; n_fail = 0;
      hit_count = 32'h2A;
      va_a = '0; da_a = '0; va_b = '0; va_c = '0; da_c = '0;
      for (int i = 0; i < 16; i++) begin
         tg_a[i] = '0; wd_a[i][0] = '0; wd_a[i][1] = '0;
      end
      for (int s = 0; s < 4; s++) begin
         tg_c[s] = 26'h0012340 + 26'(s);
         for (int w = 0; w < 4; w++) wd_c[s][w] = 32'hC0DE_0000 + 32'(s * 16 + w);
      end
      reset_all();

      // reset state
      check("rst busy", {31'd0, busy_a}, 32'd0);
      check("rst flushed", {31'd0, flushed_a}, 32'd0);
      check("rst dWEN", {31'd0, dWEN_a}, 32'd0);
      check("rst set", {29'd0, fl_set_a}, 32'd0);

      // 1: all invalid, only the hit-count write; 16*2 + 1 cycles
      hit_count = 32'h2A;
      run_flush(0, cyc);
      check("t1 cycles", 32'(cyc), 32'd33);
      check("t1 nwrites", 32'(nlog), 32'd1);
      check("t1 hit addr", log_addr[0], 32'h0000_3100);
      check("t1 hit data", log_data[0], 32'h0000_002A);
      check("t1 busy", {31'd0, busy_a}, 32'd0);
      check("t1 ninval", 32'(ninval), 32'd0);
      #1 halt_a = 1'b1;
      repeat (3) @(posedge CLK);
      #1 halt_a = 1'b0;
      check("t1 sticky", {31'd0, flushed_a}, 32'd1);
      check("t1 halt ignored", 32'(nlog), 32'd1);

      // 2: one dirty block at set 5 way 1
      reset_all();
      load_a_scenario2();
      hit_count = 32'h0000_0077;
      run_flush(0, cyc);
      check("t2 cycles", 32'(cyc), 32'd36);
      check("t2 nwrites", 32'(nlog), 32'd3);
      check("t2 addr0", log_addr[0], 32'h2AF3_7BE8);
      check("t2 data0", log_data[0], 32'h1111_1111);
      check("t2 addr1", log_addr[1], 32'h2AF3_7BEC);
      check("t2 data1", log_data[1], 32'h2222_2222);
      check("t2 addr2", log_addr[2], 32'h0000_3100);
      check("t2 data2", log_data[2], 32'h0000_0077);
      check("t2 ninval", 32'(ninval), 32'd1);
      check("t2 inval idx", {28'd0, last_inval}, 32'd11);
      check("t2 overlap", 32'(overlap), 32'd0);

      // 3: same with 3 wait states per write
      reset_all();
      load_a_scenario2();
      hit_count = 32'h0000_0077;
      stall_en = 1'b1;
      run_flush(0, cyc);
      check("t3 cycles", 32'(cyc), 32'd45);
      check("t3 nwrites", 32'(nlog), 32'd3);
      check("t3 addr0", log_addr[0], 32'h2AF3_7BE8);
      check("t3 addr1", log_addr[1], 32'h2AF3_7BEC);
      check("t3 data1", log_data[1], 32'h2222_2222);
      check("t3 addr2", log_addr[2], 32'h0000_3100);
      check("t3 stable", 32'(unstable), 32'd0);

      // 5: reset during the second word write-back, then restart
      reset_all();
      load_a_scenario2();
      hit_count = 32'h0000_0055;
      stall_en = 1'b1;
      @(posedge CLK);
      #1 halt_a = 1'b1;
      @(posedge CLK);
      #1 halt_a = 1'b0;
      k = 0;
      while (!(nlog == 1 && dWEN_a) && k < 200) begin
         @(posedge CLK);
         #1 k++;
      end
      check("t5 reached word1", {31'd0, dWEN_a}, 32'd1);
      check("t5 word1 addr", daddr_a, 32'h2AF3_7BEC);
      #2 nRST = 1'b0;
      #1;
      check("t5 async dWEN", {31'd0, dWEN_a}, 32'd0);
      check("t5 async busy", {31'd0, busy_a}, 32'd0);
      check("t5 async flushed", {31'd0, flushed_a}, 32'd0);
      model_clr = 1'b1;
      stall_en  = 1'b0;
      halt_a    = 1'b1;
      @(posedge CLK);
      #2 model_clr = 1'b0;
      #1 nRST = 1'b1;
      @(posedge CLK);
      #1 halt_a = 1'b0;
      wait_flushed(0, cyc);
      repeat (3) @(posedge CLK);
      #1;
      check("t5 start set/way", {28'd0, first_sw}, 32'd0);
      check("t5 nwrites", 32'(nlog), 32'd3);
      check("t5 addr0", log_addr[0], 32'h2AF3_7BE8);
      check("t5 data1", log_data[1], 32'h2222_2222);
      check("t5 hit data", log_data[2], 32'h0000_0055);
      check("t5 rises", 32'(rises), 32'd1);

      // 4: EMIT_HITS=0, all 16 blocks valid and clean
      reset_all();
      va_b = 16'hFFFF;
      run_flush(1, cyc);
      check("t4 cycles", 32'(cyc), 32'd48);
      check("t4 nwrites", 32'(nlog), 32'd0);
      check("t4 ninval", 32'(ninval), 32'd16);
      check("t4 busy", {31'd0, busy_b}, 32'd0);

      // 6: 4 sets x 1 way x 4 words, every block dirty
      reset_all();
      va_c = 4'hF; da_c = 4'hF;
      hit_count = 32'h0000_0C0C;
      run_flush(2, cyc);
      check("t6 cycles", 32'(cyc), 32'd29);
      check("t6 nwrites", 32'(nlog), 32'd17);
      for (int s = 0; s < 4; s++) begin
         for (int w = 0; w < 4; w++) begin
            logic [1:0] sb, wb;
            sb = 2'(s);
            wb = 2'(w);
            check($sformatf("t6 addr s%0d w%0d", s, w), log_addr[s * 4 + w],
                  {tg_c[s], sb, wb, 2'b00});
            check($sformatf("t6 data s%0d w%0d", s, w), log_data[s * 4 + w],
                  32'hC0DE_0000 + 32'(s * 16 + w));
         end
      end
      check("t6 hit addr", log_addr[16], 32'h0000_3100);
      check("t6 hit data", log_data[16], 32'h0000_0C0C);
      check("t6 ninval", 32'(ninval), 32'd4);
      check("t6 way held", 32'(way_nz), 32'd0);
      check("t6 overlap", 32'(overlap), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
